sensor_view_scheduler: RTL and testbench

SENSOR_VIEW_SCHEDULER -- requirements
Module: sensor_view_scheduler

---
 rtl/sensor_view_scheduler.sv | 158 +++++++++++++++
 tb/tb_sensor_view_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_view_scheduler.sv
// Picks which sensor reading (distance, encoder or their difference) is shown,
// with manual stepping, timed auto-rotation, display freeze and stale-sample flagging.
module sensor_view_scheduler #(
    parameter int W            = 16,
    parameter int DWELL_CYCLES = 54000000,
    parameter int STALE_CYCLES = 13500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next_pulse,
    input  logic         auto_pulse,
    input  logic         hold_pulse,
    input  logic [W-1:0] dist_value,
    input  logic         dist_valid,
    input  logic [W-1:0] enc_value,
    input  logic         enc_valid,
    output logic [1:0]   sel,
    output logic [W-1:0] display_value,
    output logic         display_update,
    output logic         auto_on,
    output logic         hold_on,
    output logic         stale,
    output logic [7:0]   dots
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } ctrl_state_t;

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int AGE_W   = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [AGE_W-1:0]   AGE_MAX    = AGE_W'(STALE_CYCLES);

    localparam logic [1:0] SEL_DIST = 2'd0;
    localparam logic [1:0] SEL_ENC  = 2'd1;
    localparam logic [1:0] SEL_DIFF = 2'd2;

    ctrl_state_t        state, state_nxt;
    logic [DWELL_W-1:0] dwell, dwell_nxt;
    logic [AGE_W-1:0]   age, age_nxt;
    logic [1:0]         sel_nxt;
    logic               hold_nxt;
    logic [W-1:0]       dist_q, enc_q;
    logic [W-1:0]       dist_nxt, enc_nxt;
    logic [W-1:0]       src_nxt;
    logic               dwell_tc;
    logic               advance;
    logic               cur_valid;
    logic               src_valid_nxt;
    logic               hold_release;
    logic               load;

    // Control FSM: mode, dwell counter and source selection.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        sel_nxt   = sel;
        dwell_tc  = (state == AUTO) && (dwell == DWELL_LAST);
        advance   = next_pulse || dwell_tc;

        if (auto_pulse) begin
            state_nxt = (state == AUTO) ? MANUAL : AUTO;
        end

        // A key press or mode toggle restarts the dwell; only AUTO lets it run.
        if (auto_pulse || next_pulse || dwell_tc || (state == MANUAL)) begin
            dwell_nxt = '0;
        end else begin
            dwell_nxt = dwell + DWELL_W'(1);
        end

        if (advance) begin
            sel_nxt = (sel == SEL_DIFF || sel == 2'd3) ? SEL_DIST : sel + 2'd1;
        end
    end

    // Sample capture and the value the display would show after this edge.
    always_comb begin
        dist_nxt = dist_valid ? dist_value : dist_q;
        enc_nxt  = enc_valid ? enc_value : enc_q;
        src_nxt  = '0;
        case (sel_nxt)
            SEL_DIST: src_nxt = dist_nxt;
            SEL_ENC:  src_nxt = enc_nxt;
            SEL_DIFF: src_nxt = dist_nxt - enc_nxt;
            default:  src_nxt = '0;
        endcase
    end

    // Display load decision; a freeze suppresses everything except the release itself.
    always_comb begin
        hold_nxt      = hold_on ^ hold_pulse;
        hold_release  = hold_on && hold_pulse;
        src_valid_nxt = 1'b0;
        case (sel_nxt)
            SEL_DIST: src_valid_nxt = dist_valid;
            SEL_ENC:  src_valid_nxt = enc_valid;
            SEL_DIFF: src_valid_nxt = dist_valid || enc_valid;
            default:  src_valid_nxt = 1'b0;
        endcase
        load = !hold_nxt && (advance || hold_release || src_valid_nxt);
    end

    // Age of the currently selected source, saturating at the stale threshold.
    always_comb begin
        cur_valid = 1'b0;
        case (sel)
            SEL_DIST: cur_valid = dist_valid;
            SEL_ENC:  cur_valid = enc_valid;
            SEL_DIFF: cur_valid = dist_valid || enc_valid;
            default:  cur_valid = 1'b0;
        endcase
        age_nxt = age;
        if (advance || cur_valid) begin
            age_nxt = '0;
        end else if (age != AGE_MAX) begin
            age_nxt = age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MANUAL;
            dwell          <= '0;
            sel            <= SEL_DIST;
            hold_on        <= 1'b0;
            dist_q         <= '0;
            enc_q          <= '0;
            age            <= '0;
            display_value  <= '0;
            display_update <= 1'b0;
        end else begin
            state          <= state_nxt;
            dwell          <= dwell_nxt;
            sel            <= sel_nxt;
            hold_on        <= hold_nxt;
            dist_q         <= dist_nxt;
            enc_q          <= enc_nxt;
            age            <= age_nxt;
            display_update <= load;
            if (load) begin
                display_value <= src_nxt;
            end
        end
    end

    // Status is decoded from registers so reset reaches the outputs without a clock.
    always_comb begin
        auto_on = (state == AUTO);
        stale   = (age == AGE_MAX);
        dots    = {auto_on, hold_on, stale, 2'b00,
                   sel == SEL_DIFF, sel == SEL_ENC, sel == SEL_DIST};
    end

endmodule

// File: tb/tb_sensor_view_scheduler.sv
// Directed bench for sensor_view_scheduler with short dwell/stale periods.
module tb_sensor_view_scheduler;

    localparam int W     = 16;
    localparam int DWELL = 8;
    localparam int STALE = 16;

    // Handshake note: all control inputs are single-cycle pulses raised after a
    // rising edge and dropped after the next one; there is no ready side.
    logic         clk;
    logic         rst_n;
    logic         next_pulse, auto_pulse, hold_pulse;
    logic [W-1:0] dist_value, enc_value;
    logic         dist_valid, enc_valid;
    logic [1:0]   sel;
    logic [W-1:0] display_value;
    logic         display_update;
    logic         auto_on, hold_on, stale;
    logic [7:0]   dots;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_view_scheduler #(
        .W(W), .DWELL_CYCLES(DWELL), .STALE_CYCLES(STALE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .next_pulse(next_pulse), .auto_pulse(auto_pulse), .hold_pulse(hold_pulse),
        .dist_value(dist_value), .dist_valid(dist_valid),
        .enc_value(enc_value), .enc_valid(enc_valid),
        .sel(sel), .display_value(display_value), .display_update(display_update),
        .auto_on(auto_on), .hold_on(hold_on), .stale(stale), .dots(dots)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        next_pulse = 1'b0;
        auto_pulse = 1'b0;
        hold_pulse = 1'b0;
        dist_valid = 1'b0;
        enc_valid  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_disp"}, 32'(display_value), 32'h0);
        check({tag, "_upd"}, 32'(display_update), 32'd0);
        check({tag, "_auto"}, 32'(auto_on), 32'd0);
        check({tag, "_hold"}, 32'(hold_on), 32'd0);
        check({tag, "_stale"}, 32'(stale), 32'd0);
        check({tag, "_dots"}, 32'(dots), 32'h01);
    endtask

    initial begin
        rst_n = 1'b0;
        next_pulse = 1'b0; auto_pulse = 1'b0; hold_pulse = 1'b0;
        dist_value = '0; dist_valid = 1'b0;
        enc_value  = '0; enc_valid  = 1'b0;
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First distance sample shows up one cycle later with a pulse
        dist_value = 16'h0123; dist_valid = 1'b1;
        tick();
        check("first_disp", 32'(display_value), 32'h0123);
        check("first_upd", 32'(display_update), 32'd1);
        check("first_dots", 32'(dots), 32'h01);
        tick();
        check("first_upd_clr", 32'(display_update), 32'd0);

        // Manual stepping through all three sources and the wrap
        dist_value = 16'h0010; dist_valid = 1'b1;
        enc_value  = 16'h0020; enc_valid  = 1'b1;
        tick();
        check("cap_disp", 32'(display_value), 32'h0010);
        next_pulse = 1'b1; tick();
        check("step1_sel", 32'(sel), 32'd1);
        check("step1_disp", 32'(display_value), 32'h0020);
        check("step1_dots", 32'(dots), 32'h02);
        next_pulse = 1'b1; tick();
        check("step2_sel", 32'(sel), 32'd2);
        check("step2_disp", 32'(display_value), 32'hFFF0);
        check("step2_upd", 32'(display_update), 32'd1);
        check("step2_dots", 32'(dots), 32'h04);
        next_pulse = 1'b1; tick();
        check("wrap_sel", 32'(sel), 32'd0);
        check("wrap_disp", 32'(display_value), 32'h0010);

        // Encoder sample while showing distance is captured but not displayed
        enc_value = 16'h0030; enc_valid = 1'b1; tick();
        check("enc_ignored_upd", 32'(display_update), 32'd0);
        check("enc_ignored_disp", 32'(display_value), 32'h0010);

        // Auto-rotation every 8 cycles
        auto_pulse = 1'b1; tick();
        check("auto_on", 32'(auto_on), 32'd1);
        check("auto_dots", 32'(dots), 32'h81);
        ticks(DWELL - 1);
        check("dwell_pre1", 32'(sel), 32'd0);
        tick();
        check("dwell_adv1", 32'(sel), 32'd1);
        check("dwell_adv1_disp", 32'(display_value), 32'h0030);
        check("dwell_adv1_upd", 32'(display_update), 32'd1);
        ticks(DWELL);
        check("dwell_adv2", 32'(sel), 32'd2);
        check("dwell_adv2_disp", 32'(display_value), 32'hFFE0);
        ticks(DWELL);
        check("dwell_adv3", 32'(sel), 32'd0);

        // Key press on the terminal-count cycle advances exactly once
        ticks(DWELL - 1);
        check("tc_pre", 32'(sel), 32'd0);
        next_pulse = 1'b1; tick();
        check("tc_single", 32'(sel), 32'd1);
        ticks(DWELL - 1);
        check("tc_restart_pre", 32'(sel), 32'd1);
        tick();
        check("tc_restart_adv", 32'(sel), 32'd2);

        // auto + next together: leave AUTO and advance once
        auto_pulse = 1'b1; next_pulse = 1'b1; tick();
        check("both_auto", 32'(auto_on), 32'd0);
        check("both_sel", 32'(sel), 32'd0);
        ticks(10);
        check("manual_still", 32'(sel), 32'd0);

        // Freeze: captured sample is not shown until release
        hold_pulse = 1'b1; tick();
        check("hold_on", 32'(hold_on), 32'd1);
        check("hold_dots", 32'(dots), 32'h41);
        dist_value = 16'h0555; dist_valid = 1'b1; tick();
        check("hold_frozen_disp", 32'(display_value), 32'h0010);
        check("hold_frozen_upd", 32'(display_update), 32'd0);
        hold_pulse = 1'b1; tick();
        check("release_disp", 32'(display_value), 32'h0555);
        check("release_upd", 32'(display_update), 32'd1);
        check("release_dots", 32'(dots), 32'h01);

        // Staleness on the encoder source
        next_pulse = 1'b1; tick();
        check("enc_sel_disp", 32'(display_value), 32'h0030);
        ticks(STALE - 1);
        check("stale_pre", 32'(stale), 32'd0);
        tick();
        check("stale_set", 32'(stale), 32'd1);
        check("stale_dots", 32'(dots), 32'h22);
        ticks(3);
        check("stale_sat", 32'(stale), 32'd1);
        enc_value = 16'h0031; enc_valid = 1'b1; tick();
        check("stale_clr", 32'(stale), 32'd0);
        check("stale_clr_disp", 32'(display_value), 32'h0031);
        check("stale_clr_dots", 32'(dots), 32'h02);

        // Difference view
        next_pulse = 1'b1; tick();
        check("diff_disp", 32'(display_value), 32'h0524);

        // Asynchronous reset mid-auto and mid-hold
        auto_pulse = 1'b1; tick();
        hold_pulse = 1'b1; tick();
        ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ticks(DWELL + 2);
        check("post_rst_sel", 32'(sel), 32'd0);
        dist_value = 16'h0042; dist_valid = 1'b1; tick();
        check("post_rst_disp", 32'(display_value), 32'h0042);
        check("post_rst_upd", 32'(display_update), 32'd1);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
